// File: rtl/rect_bounce_painter.sv
// Paints NRECT bouncing rectangles over a flat background, one pipeline stage
// between the timing generator and the DVI output registers.
module rect_bounce_painter #(
  parameter int                     CORDW    = 10,
  parameter int                     CHW      = 4,
  parameter int                     H_RES    = 640,
  parameter int                     V_RES    = 480,
  parameter int                     NRECT    = 4,
  parameter int                     RECT_W   = 40,
  parameter int                     RECT_H   = 40,
  parameter int                     SPEED    = 2,
  parameter logic                   SYNC_POL = 1'b0,
  parameter logic [3*CHW-1:0]       BG_RGB   = 12'h137,
  parameter logic [NRECT*3*CHW-1:0] FG_RGB   = {NRECT{12'hF0F}}
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             en_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o,
  output logic [CHW-1:0]   r_o,
  output logic [CHW-1:0]   g_o,
  output logic [CHW-1:0]   b_o,
  output logic             frame_o,
  output logic [NRECT-1:0] bounce_o
);

  localparam int               CW     = 3 * CHW;
  localparam logic [CORDW:0]   X_LIM  = (CORDW+1)'(H_RES - RECT_W);
  localparam logic [CORDW:0]   Y_LIM  = (CORDW+1)'(V_RES - RECT_H);
  localparam logic [CORDW:0]   SPD    = (CORDW+1)'(SPEED);
  localparam logic [CORDW:0]   RW     = (CORDW+1)'(RECT_W);
  localparam logic [CORDW:0]   RH     = (CORDW+1)'(RECT_H);
  localparam logic [CORDW-1:0] V_LINE = CORDW'(V_RES);

  if (NRECT < 1 || NRECT > 8 || SPEED < 1 || SPEED > RECT_W ||
      NRECT * (RECT_W + RECT_W / 2) > H_RES - RECT_W) begin : g_bad_params
    $error("rect_bounce_painter: illegal parameter combination");
  end

  logic [CORDW-1:0] x_q [NRECT];
  logic [CORDW-1:0] y_q [NRECT];
  logic [CORDW-1:0] x_d [NRECT];
  logic [CORDW-1:0] y_d [NRECT];
  logic [NRECT-1:0] xneg_q, yneg_q, xneg_d, yneg_d, bounce_d;
  logic [CORDW:0]   x_step, y_step;
  logic [CW-1:0]    pix;
  logic             strobe;

  // Result MSB flags a reversal; the low CORDW bits are the new position.
  function automatic logic [CORDW:0] step_axis(input logic [CORDW-1:0] pos,
                                               input logic neg,
                                               input logic [CORDW:0] lim);
    logic [CORDW:0] p;
    logic [CORDW:0] nxt;
    p = {1'b0, pos};
    if (!neg) begin
      nxt = p + SPD;
      if (nxt >= lim) return {1'b1, lim[CORDW-1:0]};
      return {1'b0, nxt[CORDW-1:0]};
    end
    if (p <= SPD) return {1'b1, {CORDW{1'b0}}};
    nxt = p - SPD;
    return {1'b0, nxt[CORDW-1:0]};
  endfunction

  assign strobe = (sy == V_LINE) && (sx == '0);

  always_comb begin
    x_step   = '0;
    y_step   = '0;
    xneg_d   = xneg_q;
    yneg_d   = yneg_q;
    bounce_d = '0;
    for (int i = 0; i < NRECT; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      if (strobe && en_i) begin
        x_step      = step_axis(x_q[i], xneg_q[i], X_LIM);
        y_step      = step_axis(y_q[i], yneg_q[i], Y_LIM);
        x_d[i]      = x_step[CORDW-1:0];
        y_d[i]      = y_step[CORDW-1:0];
        xneg_d[i]   = xneg_q[i] ^ x_step[CORDW];
        yneg_d[i]   = yneg_q[i] ^ y_step[CORDW];
        bounce_d[i] = x_step[CORDW] | y_step[CORDW];
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      for (int i = 0; i < NRECT; i++) begin
        x_q[i] <= CORDW'(i * (RECT_W + RECT_W / 2));
        y_q[i] <= CORDW'(i * (RECT_H / 2));
      end
      xneg_q <= '0;
      yneg_q <= '0;
    end else begin
      for (int i = 0; i < NRECT; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      xneg_q <= xneg_d;
      yneg_q <= yneg_d;
    end
  end

  // Walk from the highest index down so the lowest overlapping rect wins.
  always_comb begin
    pix = BG_RGB;
    for (int i = NRECT - 1; i >= 0; i--) begin
      if ({1'b0, sx} >= {1'b0, x_q[i]} && {1'b0, sx} < {1'b0, x_q[i]} + RW &&
          {1'b0, sy} >= {1'b0, y_q[i]} && {1'b0, sy} < {1'b0, y_q[i]} + RH)
        pix = FG_RGB[i*CW +: CW];
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      hsync_o  <= ~SYNC_POL;
      vsync_o  <= ~SYNC_POL;
      de_o     <= 1'b0;
      r_o      <= '0;
      g_o      <= '0;
      b_o      <= '0;
      frame_o  <= 1'b0;
      bounce_o <= '0;
    end else begin
      hsync_o  <= hsync;
      vsync_o  <= vsync;
      de_o     <= de;
      r_o      <= de ? pix[CW-1 -: CHW]    : '0;
      g_o      <= de ? pix[2*CHW-1 -: CHW] : '0;
      b_o      <= de ? pix[CHW-1:0]        : '0;
      frame_o  <= strobe;
      bounce_o <= bounce_d;
    end
  end

endmodule

// File: tb/tb_rect_bounce_painter.sv
// Directed bench: a full-size painter plus a small 160x160 painter with a
// large step, so clamped edge hits, corners and overlaps come up quickly.
module tb_rect_bounce_painter;

  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b1;
  logic [9:0] sx = '0, sy = '0;
  logic       de = 1'b0, hsync = 1'b1, vsync = 1'b1, en_i = 1'b1;

  logic       a_hs, a_vs, a_de, a_frame;
  logic [3:0] a_r, a_g, a_b, a_bounce;
  logic       b_hs, b_vs, b_de, b_frame;
  logic [3:0] b_r, b_g, b_b;
  logic [1:0] b_bounce;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_pix = ~clk_pix;

  rect_bounce_painter #(
    .FG_RGB({12'h0FF, 12'h00F, 12'h0F0, 12'hF00})
  ) dut_a (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
    .hsync(hsync), .vsync(vsync), .en_i(en_i),
    .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de),
    .r_o(a_r), .g_o(a_g), .b_o(a_b), .frame_o(a_frame), .bounce_o(a_bounce)
  );

  rect_bounce_painter #(
    .H_RES(160), .V_RES(160), .NRECT(2), .SPEED(7),
    .FG_RGB({12'h0F0, 12'hF00})
  ) dut_b (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .de(de),
    .hsync(hsync), .vsync(vsync), .en_i(en_i),
    .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de),
    .r_o(b_r), .g_o(b_g), .b_o(b_b), .frame_o(b_frame), .bounce_o(b_bounce)
  );

  task automatic drive_pixel(input int x, input int y, input logic d);
    sx = 10'(x); sy = 10'(y); de = d;
    @(posedge clk_pix); #1;
  endtask

  task automatic strobe(input int line);
    sx = '0; sy = 10'(line); de = 1'b0;
    @(posedge clk_pix); #1;
  endtask

  task automatic idle(input int line);
    sx = 10'd1; sy = 10'(line); de = 1'b0;
    @(posedge clk_pix); #1;
  endtask

  task automatic test_reset;
    rst_pix = 1'b1; sx = '0; sy = '0; de = 1'b1; hsync = 1'b0; vsync = 1'b0;
    repeat (2) @(posedge clk_pix);
    #1;
    tests_run++;
    if ({a_de, a_r, a_g, a_b, a_frame, a_bounce} !== 18'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got de=%b rgb=%h%h%h frame=%b bounce=%b want all 0",
               a_de, a_r, a_g, a_b, a_frame, a_bounce);
    end
    tests_run++;
    if ({a_hs, a_vs, b_hs, b_vs} !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL reset_sync got %b want 1111", {a_hs, a_vs, b_hs, b_vs});
    end
    tests_run++;
    if (dut_a.x_q[1] !== 10'd60 || dut_a.y_q[1] !== 10'd20) begin
      tests_failed++;
      $display("[TB] FAIL reset_rect1 got (%0d,%0d) want (60,20)", dut_a.x_q[1], dut_a.y_q[1]);
    end
    tests_run++;
    if (dut_a.x_q[3] !== 10'd180 || dut_a.y_q[3] !== 10'd60) begin
      tests_failed++;
      $display("[TB] FAIL reset_rect3 got (%0d,%0d) want (180,60)", dut_a.x_q[3], dut_a.y_q[3]);
    end
  endtask

  task automatic test_latency;
    rst_pix = 1'b0; vsync = 1'b1;
    drive_pixel(0, 0, 1'b1);
    tests_run++;
    if ({a_r, a_g, a_b} !== 12'hF00 || a_de !== 1'b1 || a_hs !== 1'b0 || a_vs !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL latency_fg0 got rgb=%h de=%b hs=%b vs=%b want F00 1 0 1",
               {a_r, a_g, a_b}, a_de, a_hs, a_vs);
    end
    hsync = 1'b1;
    drive_pixel(40, 0, 1'b1);
    tests_run++;
    if ({a_r, a_g, a_b} !== 12'h137 || a_hs !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL latency_bg got rgb=%h hs=%b want 137 1", {a_r, a_g, a_b}, a_hs);
    end
    drive_pixel(60, 20, 1'b1);
    tests_run++;
    if ({a_r, a_g, a_b} !== 12'h0F0) begin
      tests_failed++;
      $display("[TB] FAIL rect1_corner got %h want 0F0", {a_r, a_g, a_b});
    end
    drive_pixel(59, 20, 1'b1);
    tests_run++;
    if ({a_r, a_g, a_b} !== 12'h137) begin
      tests_failed++;
      $display("[TB] FAIL rect1_left_edge got %h want 137", {a_r, a_g, a_b});
    end
    drive_pixel(0, 0, 1'b0);
    tests_run++;
    if ({a_r, a_g, a_b} !== 12'h000 || a_de !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL blank_black got rgb=%h de=%b want 000 0", {a_r, a_g, a_b}, a_de);
    end
  endtask

  task automatic test_right_bounce;
    logic [3:0] want;
    en_i = 1'b1;
    for (int k = 1; k <= 301; k++) begin
      strobe(480);
      case (k)
        190:     want = 4'b1000;
        200:     want = 4'b0100;
        210:     want = 4'b1010;
        220:     want = 4'b0001;
        240:     want = 4'b0100;
        270:     want = 4'b0010;
        300:     want = 4'b0001;
        default: want = 4'b0000;
      endcase
      tests_run++;
      if (a_bounce !== want || a_frame !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL bounce_a k=%0d got bounce=%b frame=%b want %b 1", k, a_bounce, a_frame, want);
      end
      if (k == 300) begin
        tests_run++;
        if (dut_a.x_q[0] !== 10'd600 || dut_a.y_q[0] !== 10'd280) begin
          tests_failed++;
          $display("[TB] FAIL right_edge got (%0d,%0d) want (600,280)", dut_a.x_q[0], dut_a.y_q[0]);
        end
      end
      idle(480);
      if (k == 1) begin
        tests_run++;
        if (a_frame !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL frame_width got %b want 0", a_frame);
        end
      end
      if (k == 300) begin
        drive_pixel(639, 319, 1'b1);
        tests_run++;
        if ({a_r, a_g, a_b} !== 12'hF00) begin
          tests_failed++;
          $display("[TB] FAIL right_pixel_in got %h want F00", {a_r, a_g, a_b});
        end
        drive_pixel(639, 320, 1'b1);
        tests_run++;
        if ({a_r, a_g, a_b} !== 12'h137) begin
          tests_failed++;
          $display("[TB] FAIL right_pixel_out got %h want 137", {a_r, a_g, a_b});
        end
      end
    end
    tests_run++;
    if (dut_a.x_q[0] !== 10'd598 || dut_a.y_q[0] !== 10'd278) begin
      tests_failed++;
      $display("[TB] FAIL after_bounce got (%0d,%0d) want (598,278)", dut_a.x_q[0], dut_a.y_q[0]);
    end
  endtask

  task automatic test_overlap;
    en_i = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      strobe(160);
      tests_run++;
      if (b_bounce !== ((k == 9) ? 2'b10 : 2'b00)) begin
        tests_failed++;
        $display("[TB] FAIL bounce_b k=%0d got %b want %b", k, b_bounce, (k == 9) ? 2'b10 : 2'b00);
      end
      idle(160);
    end
    tests_run++;
    if (dut_b.x_q[1] !== 10'd106 || dut_b.y_q[1] !== 10'd97) begin
      tests_failed++;
      $display("[TB] FAIL clamp_return got (%0d,%0d) want (106,97)", dut_b.x_q[1], dut_b.y_q[1]);
    end
    drive_pixel(108, 100, 1'b1);
    tests_run++;
    if ({b_r, b_g, b_b} !== 12'hF00) begin
      tests_failed++;
      $display("[TB] FAIL overlap_priority got %h want F00", {b_r, b_g, b_b});
    end
    drive_pixel(120, 120, 1'b1);
    tests_run++;
    if ({b_r, b_g, b_b} !== 12'h0F0) begin
      tests_failed++;
      $display("[TB] FAIL overlap_rect1_only got %h want 0F0", {b_r, b_g, b_b});
    end
    drive_pixel(150, 100, 1'b1);
    tests_run++;
    if ({b_r, b_g, b_b} !== 12'h137) begin
      tests_failed++;
      $display("[TB] FAIL overlap_bg got %h want 137", {b_r, b_g, b_b});
    end
  endtask

  task automatic test_corner;
    logic [1:0] want;
    for (int k = 12; k <= 36; k++) begin
      strobe(160);
      case (k)
        15, 27, 33: want = 2'b10;
        18, 36:     want = 2'b01;
        default:    want = 2'b00;
      endcase
      tests_run++;
      if (b_bounce !== want) begin
        tests_failed++;
        $display("[TB] FAIL bounce_b k=%0d got %b want %b", k, b_bounce, want);
      end
      if (k == 18 || k == 19 || k == 36) begin
        tests_run++;
        if (dut_b.x_q[0] !== ((k == 18) ? 10'd120 : (k == 19) ? 10'd113 : 10'd0) ||
            dut_b.y_q[0] !== ((k == 18) ? 10'd120 : (k == 19) ? 10'd113 : 10'd0)) begin
          tests_failed++;
          $display("[TB] FAIL corner_pos k=%0d got (%0d,%0d)", k, dut_b.x_q[0], dut_b.y_q[0]);
        end
      end
      idle(160);
      if (k == 36) begin
        tests_run++;
        if (b_bounce !== 2'b00) begin
          tests_failed++;
          $display("[TB] FAIL corner_single_pulse got %b want 00", b_bounce);
        end
      end
    end
    drive_pixel(0, 0, 1'b1);
    tests_run++;
    if ({b_r, b_g, b_b} !== 12'hF00) begin
      tests_failed++;
      $display("[TB] FAIL corner_pixel got %h want F00", {b_r, b_g, b_b});
    end
  endtask

  task automatic test_freeze_reset;
    int frames = 0;
    en_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      strobe(480);
      frames += int'(a_frame);
      tests_run++;
      if (a_bounce !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL freeze_bounce got %b want 0000", a_bounce);
      end
      idle(480);
      frames += int'(a_frame);
    end
    tests_run++;
    if (frames != 3) begin
      tests_failed++;
      $display("[TB] FAIL freeze_frames got %0d want 3", frames);
    end
    tests_run++;
    if (dut_a.x_q[0] !== 10'd598 || dut_a.y_q[0] !== 10'd278 ||
        dut_a.x_q[1] !== 10'd538 || dut_a.y_q[1] !== 10'd258) begin
      tests_failed++;
      $display("[TB] FAIL freeze_pos got r0=(%0d,%0d) r1=(%0d,%0d) want (598,278) (538,258)",
               dut_a.x_q[0], dut_a.y_q[0], dut_a.x_q[1], dut_a.y_q[1]);
    end
    en_i = 1'b1;
    rst_pix = 1'b1;
    drive_pixel(100, 200, 1'b1);
    tests_run++;
    if (a_de !== 1'b0 || {a_r, a_g, a_b} !== 12'h000 || a_hs !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset_out got de=%b rgb=%h hs=%b want 0 000 1",
               a_de, {a_r, a_g, a_b}, a_hs);
    end
    tests_run++;
    if (dut_a.x_q[0] !== 10'd0 || dut_a.y_q[0] !== 10'd0 ||
        dut_a.x_q[1] !== 10'd60 || dut_a.y_q[1] !== 10'd20) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset_pos got r0=(%0d,%0d) r1=(%0d,%0d) want (0,0) (60,20)",
               dut_a.x_q[0], dut_a.y_q[0], dut_a.x_q[1], dut_a.y_q[1]);
    end
    rst_pix = 1'b0;
    drive_pixel(60, 20, 1'b1);
    tests_run++;
    if ({a_r, a_g, a_b} !== 12'h0F0) begin
      tests_failed++;
      $display("[TB] FAIL resume_paint got %h want 0F0", {a_r, a_g, a_b});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_right_bounce();
    test_overlap();
    test_corner();
    test_freeze_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
